// File: rtl/ten_bit_incrementer.sv
// Registered WIDTH-bit +1 incrementer with carry-out, built as GROUP-bit carry-lookahead blocks.
// The sum and carry are combinational; s/o/valid are registered with one-cycle latency.

module ten_bit_incrementer_group #(
    parameter int GROUP = 5
) (
    input  logic [GROUP-1:0] a,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p
);
    logic [GROUP-1:0] c;

    // Prefix carries inside the group: c[i] is cin AND all lower bits of a.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 1; i < GROUP; i++) c[i] = c[i-1] & a[i-1];
    end

    assign s = a ^ c;
    assign p = &a;
endmodule

module ten_bit_incrementer #(
    parameter int WIDTH = 10,
    parameter int GROUP = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] s,
    output logic             o,
    output logic             valid
);
    // WIDTH is expected to be a whole number of groups.
    localparam int NUM_GROUPS = WIDTH / GROUP;

    logic [NUM_GROUPS-1:0][GROUP-1:0] a_grp;
    logic [NUM_GROUPS-1:0][GROUP-1:0] s_grp;
    logic [NUM_GROUPS-1:0]            grp_p;
    logic [NUM_GROUPS-1:0]            grp_c;
    logic [WIDTH-1:0]                 sum;
    logic                             carry;

    assign a_grp = a;

    // Group carry-in is the AND of every lower group's propagate (carry-in to the adder is 1).
    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
        if (k == 0) begin : g_first
            assign grp_c[k] = 1'b1;
        end else begin : g_rest
            assign grp_c[k] = &grp_p[k-1:0];
        end

        ten_bit_incrementer_group #(.GROUP(GROUP)) u_grp (
            .a   (a_grp[k]),
            .cin (grp_c[k]),
            .s   (s_grp[k]),
            .p   (grp_p[k])
        );
    end

    assign sum   = s_grp;
    assign carry = &grp_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s     <= '0;
            o     <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                s <= sum;
                o <= carry;
            end
        end
    end
endmodule

// File: tb/tb_ten_bit_incrementer.sv
// Scoreboarded bench for ten_bit_incrementer: directed plan, exhaustive sweep and random traffic
// against an arithmetic reference model.

module tb_ten_bit_incrementer;
    localparam int WIDTH = 10;
    localparam int MAXV  = (1 << WIDTH) - 1;

    typedef struct {
        int unsigned s;
        bit          o;
        int unsigned a;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] s;
    logic             o;
    logic             valid;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;

    // Model of the registered outputs, computed from the arithmetic definition.
    int unsigned m_s = 0;
    bit          m_o = 1'b0;
    bit          m_v = 1'b0;

    ten_bit_incrementer #(.WIDTH(WIDTH), .GROUP(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .s     (s),
        .o     (o),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle, update the model, then compare registered outputs just after the edge.
    task automatic step(input string name, input bit r, input bit e, input int unsigned v);
        rst_n = r;
        en    = e;
        a     = v[WIDTH-1:0];
        if (!r) begin
            m_s = 0; m_o = 0; m_v = 0;
        end else if (e) begin
            m_s = (v + 1) % (MAXV + 1);
            m_o = (v == MAXV);
            m_v = 1;
            sb_q.push_back('{s: m_s, o: m_o, a: v});
        end else begin
            m_v = 0;
        end
        @(posedge clk);
        #1;
        check({name, ".s"}, 32'(s), m_s);
        check({name, ".o"}, 32'(o), 32'(m_o));
        check({name, ".valid"}, 32'(valid), 32'(m_v));
    endtask

    // Monitor: every valid result must match the oldest outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: valid with s=%0d, expected no result", s);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("sb a=%0d s", e.a), 32'(s), e.s);
                    check($sformatf("sb a=%0d o", e.a), 32'(o), 32'(e.o));
                end
            end
        end
    end

    initial begin
        // Reset and basic counting.
        step("reset", 0, 0, 0);
        step("reset2", 0, 1, 3);
        step("a0", 1, 1, 0);
        step("a1", 1, 1, 1);
        step("a2", 1, 1, 2);
        // Wrap-around.
        step("a1022", 1, 1, 1022);
        step("a1023", 1, 1, 1023);
        // Group boundaries.
        step("a31", 1, 1, 31);
        step("a511", 1, 1, 511);
        step("a992", 1, 1, 992);
        // Hold with a changing.
        step("a5", 1, 1, 5);
        for (int i = 0; i < 3; i++) step("hold", 1, 0, 100);
        // Reset mid-operation discards the concurrent capture.
        step("a1023b", 1, 1, 1023);
        step("rst_mid", 0, 1, 7);
        step("a7", 1, 1, 7);
        // Exhaustive sweep.
        for (int v = 0; v <= MAXV; v++) step("sweep", 1, 1, v);
        // Random traffic with holds and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            int unsigned r;
            r = $urandom_range(99);
            step("rand", (r >= 3), (r >= 30), $urandom_range(MAXV));
        end
        step("drain", 1, 0, 0);
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ten_bit_incrementer.md
Name: ten_bit_incrementer

Overview:
- Registered 10-bit unsigned incrementer (+1) with carry-out/overflow flag.
- Serves as a building block for the CPU datapath, e.g. program-counter advance and loop/address counters.
- The incrementing logic is purely combinational; the result and overflow flag are captured in output registers with one-cycle latency.

Parameters:
- WIDTH, 10, operand/result width in bits. The 10-bit configuration is the required one; other values only need to work if they fall out naturally.
- GROUP, 5, bit-group size for the carry-lookahead structure. WIDTH must be a multiple of GROUP.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  load enable; when high, the incremented value of a is captured this cycle.
- a  input  WIDTH  unsigned operand.
- s  output  WIDTH  registered sum, a + 1 modulo 2^WIDTH.
- o  output  1  registered carry-out; 1 exactly when a was all ones.
- valid  output  1  high for one cycle after each cycle in which en was accepted.

Behaviour:
- Reset: on a rising edge of clk with rst_n = 0, set s = 0, o = 0, valid = 0. Reset has priority over en.
- Reset mid-operation: a result captured in the same edge is discarded; outputs read 0 on the following cycle.
- Normal operation: on a rising edge with rst_n = 1 and en = 1:
  - s <= a + 1, truncated to WIDTH bits.
  - o <= AND of all bits of a.
  - valid <= 1.
- Hold: on a rising edge with rst_n = 1 and en = 0, s and o keep their previous values and valid <= 0.
- Latency: one clock edge from a/en to s/o/valid. There is no combinational path from any input to any output.
- Arithmetic: unsigned. Carry-in is fixed at 1.
  - Per bit: s_i = a_i XOR c_i and c_(i+1) = a_i AND c_i, with c_0 = 1.
  - o = c_WIDTH.
- Wrap-around: a = 1023 gives s = 0 and o = 1. This is the only input that sets o.
- Carry structure: carry-lookahead, not a 10-stage ripple.
  - Each GROUP-bit group computes a group propagate (AND of its bits) and internal prefix carries.
  - The carry into group k is the AND of the group propagates of all lower groups.
  - The result must be bit-identical to a + 1 for all 1024 inputs.
- No X propagation after reset: with known inputs, every output is 0/1 from the first post-reset edge.
- Input a is don't-care while en = 0 or rst_n = 0.

Test Plan:
- Reset, then en=1 with a=0 -> next cycle s=1, o=0, valid=1; then a=1 -> s=2, o=0; then a=2 -> s=3, o=0.
- en=1, a=10'b1111111110 (1022) -> s=1023, o=0; next a=10'b1111111111 (1023) -> s=0, o=1, valid=1.
- Group boundary: a=31 (lower group all ones) -> s=32, o=0; a=511 -> s=512, o=0.
- Hold: load a=5 (s=6), then en=0 with a=100 for 3 cycles -> s stays 6, o stays 0, valid=0.
- Reset mid-operation: after s=0, o=1 (from a=1023), assert rst_n=0 with en=1, a=7 -> next cycle s=0, o=0, valid=0. Release reset -> a=7 gives s=8.
- Exhaustive: sweep a=0..1023 with en=1 -> every result equals (a+1) mod 1024 and o=(a==1023), one cycle later.
